pipe_fetch_ctrl: RTL and testbench
==================================

PIPE_FETCH_CTRL -- requirements
Module: pipe_fetch_ctrl

Interface
REQ-001 The block SHALL have one clock domain, and reset SHALL be asynchronous and active-low.
REQ-002 clock  in  1  rising-edge clock for all state.
REQ-003 resetn  in  1  asynchronous active-low reset.
REQ-004 pcsource  in  2  next-PC select from ID: 00 pc+4, 01 bpc, 10 jpc, 11 rpc; valid only when wpcir=1.
REQ-005 bpc, jpc, rpc  in  32 each  branch, jump and register targets from ID.
REQ-006 wpcir  in  1  1 = PC and IF/ID may advance; 0 = load-use stall.
REQ-007 imem_req  out  1  instruction-memory request.
REQ-008 imem_addr  out  32  fetch address, always equal to pc.
REQ-009 imem_ack  in  1  memory response; imem_rdata is valid in the same cycle.
REQ-010 imem_rdata  in  32  fetched instruction.
REQ-011 pc  out  32  current fetch PC register.
REQ-012 f_valid, f_inst, f_pc4  out  1/32/32  fetch result presented to the external IF/ID register, which loads when wpcir=1.
REQ-013 stall_cnt  out  32  memory-wait cycle count (see Configuration).

Function
REQ-014 FSM states SHALL be IDLE, FETCH and HOLD.
REQ-015 IDLE SHALL drive imem_req=0 and f_valid=0, and SHALL go to FETCH on the first clock after resetn deasserts.
REQ-016 FETCH SHALL drive imem_req=1 and imem_addr=pc, and SHALL drive f_valid=imem_ack, f_inst=imem_rdata and f_pc4=pc+4.
REQ-017 FETCH with imem_ack=1 and wpcir=1: pc SHALL load the next PC and the FSM SHALL stay in FETCH, giving back-to-back fetch with no idle cycle.
REQ-018 FETCH with imem_ack=1 and wpcir=0: imem_rdata and pc+4 SHALL be captured into hold registers, the FSM SHALL go to HOLD, and pc SHALL be unchanged.
REQ-019 FETCH with imem_ack=0: pc SHALL be unchanged and f_valid=0, which inserts a bubble into IF/ID.
REQ-020 HOLD SHALL drive imem_req=0, f_valid=1, f_inst=hold_inst and f_pc4=hold_pc4.
REQ-021 HOLD with wpcir=1: pc SHALL load the next PC and the FSM SHALL go to FETCH.
REQ-022 Next PC SHALL be: pend_pc if pend_v=1; else if pcsource!=00 and wpcir=1, the selected bpc/jpc/rpc; else pc+4.
REQ-023 The cycle pc loads the next PC, pend_v SHALL clear.
REQ-024 Pending redirect: if wpcir=1 and pcsource!=00 in a cycle where pc does not advance, pend_v SHALL set to 1 and pend_pc SHALL capture the selected target.
REQ-025 If pend_v=1 and a new pcsource!=00 arrives, the pending target SHALL win and the new request SHALL be ignored (a branch in the delay slot is illegal).
REQ-026 pcsource SHALL be ignored whenever wpcir=0.
REQ-027 The delay-slot instruction (the fetch in flight when the redirect arrives) SHALL be delivered, not flushed.
REQ-028 pc+4 SHALL wrap modulo 2^32 (0xFFFFFFFC+4 = 0x00000000), and targets SHALL be used unmodified.
REQ-029 imem_ack received in IDLE or HOLD SHALL be ignored.

Reset
REQ-030 On resetn=0, the block SHALL asynchronously set: state=IDLE, pc=0, pend_v=0, pend_pc=0, hold_inst=0, hold_pc4=0, stall_cnt=0.
REQ-031 During reset, outputs SHALL be imem_req=0, f_valid=0 and imem_addr=0.
REQ-032 Reset asserted mid-fetch SHALL abandon the outstanding request, and after release the first request SHALL be to address 0.

Configuration
REQ-033 With FETCH_STALL_CNT_EN defined, stall_cnt SHALL increment on each FETCH cycle with imem_ack=0 and saturate at 0xFFFFFFFF.
REQ-034 Without FETCH_STALL_CNT_EN, the stall_cnt port SHALL remain and be driven constant 0, and no counter logic SHALL be present.

Verification
REQ-035 Reset release with imem_ack held at 1 and wpcir=1 -> imem_addr sequence 0,4,8,C on consecutive cycles, with f_valid=1 from the second cycle.
REQ-036 At pc=0x10, pcsource=01 and bpc=0x100 with an ack in the same cycle -> next imem_addr=0x100, with no pend_v set.
REQ-037 At pc=0x20 with ack=0, pulse pcsource=10 and jpc=0x400 for 1 cycle, then ack 3 cycles later -> instruction at 0x20 delivered, next imem_addr=0x400.
REQ-038 Ack with wpcir=0 for 2 cycles -> HOLD, imem_req=0, f_inst stable; wpcir=1 -> pc advances by 4 and the FSM re-enters FETCH.
REQ-039 pc=0xFFFFFFFC with an ack -> pc=0x00000000; with the macro defined, 5 no-ack cycles -> stall_cnt=5.
REQ-040 resetn pulsed low while a FETCH is outstanding -> IDLE, pc=0, pend_v=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pipe_fetch_ctrl.sv
// Instruction fetch controller: PC register, IDLE/FETCH/HOLD FSM, pending redirect.
// Optional memory-wait counter enabled by defining FETCH_STALL_CNT_EN.
module pipe_fetch_ctrl (
    input  logic        clock,
    input  logic        resetn,
    input  logic [1:0]  pcsource,
    input  logic [31:0] bpc,
    input  logic [31:0] jpc,
    input  logic [31:0] rpc,
    input  logic        wpcir,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic        f_valid,
    output logic [31:0] f_inst,
    output logic [31:0] f_pc4,
    output logic [31:0] stall_cnt
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        pend_v_q, pend_v_d;
    logic [31:0] pend_pc_q, pend_pc_d;
    logic [31:0] hold_inst_q, hold_inst_d;
    logic [31:0] hold_pc4_q, hold_pc4_d;

    logic [31:0] pc_plus4;
    logic [31:0] target;
    logic [31:0] next_pc;
    logic        redir;
    logic        advance;
    logic        in_fetch;
    logic        in_hold;

    assign in_fetch = (state_q == FETCH);
    assign in_hold  = (state_q == HOLD);
    assign pc_plus4 = pc_q + 32'd4;
    assign redir    = wpcir && (pcsource != 2'b00);

    always_comb begin
        target = pc_plus4;
        unique case (1'b1)
            (pcsource == 2'b01): target = bpc;
            (pcsource == 2'b10): target = jpc;
            (pcsource == 2'b11): target = rpc;
            default:             target = pc_plus4;
        endcase
    end

    // A redirect already parked wins over anything arriving later.
    always_comb begin
        next_pc = pc_plus4;
        if (pend_v_q) begin
            next_pc = pend_pc_q;
        end else if (redir) begin
            next_pc = target;
        end
    end

    assign advance = (in_fetch && imem_ack && wpcir) || (in_hold && wpcir);

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        pend_v_d    = pend_v_q;
        pend_pc_d   = pend_pc_q;
        hold_inst_d = hold_inst_q;
        hold_pc4_d  = hold_pc4_q;

        case (state_q)
            IDLE: begin
                state_d = FETCH;
            end
            FETCH: begin
                if (imem_ack && !wpcir) begin
                    state_d     = HOLD;
                    hold_inst_d = imem_rdata;
                    hold_pc4_d  = pc_plus4;
                end
            end
            HOLD: begin
                if (wpcir) begin
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (advance) begin
            pc_d     = next_pc;
            pend_v_d = 1'b0;
        end else if (redir && !pend_v_q) begin
            pend_v_d  = 1'b1;
            pend_pc_d = target;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            pc_q        <= 32'd0;
            pend_v_q    <= 1'b0;
            pend_pc_q   <= 32'd0;
            hold_inst_q <= 32'd0;
            hold_pc4_q  <= 32'd0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            pend_v_q    <= pend_v_d;
            pend_pc_q   <= pend_pc_d;
            hold_inst_q <= hold_inst_d;
            hold_pc4_q  <= hold_pc4_d;
        end
    end

    always_comb begin
        imem_req = 1'b0;
        f_valid  = 1'b0;
        f_inst   = 32'd0;
        f_pc4    = 32'd0;
        if (in_fetch) begin
            imem_req = 1'b1;
            f_valid  = imem_ack;
            f_inst   = imem_rdata;
            f_pc4    = pc_plus4;
        end else if (in_hold) begin
            f_valid  = 1'b1;
            f_inst   = hold_inst_q;
            f_pc4    = hold_pc4_q;
        end
    end

    assign imem_addr = pc_q;
    assign pc        = pc_q;

`ifdef FETCH_STALL_CNT_EN
    logic [31:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (in_fetch && !imem_ack && (stall_q != 32'hFFFF_FFFF)) begin
            stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            stall_q <= 32'd0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_fetch_ctrl.sv
// Self-checking bench for pipe_fetch_ctrl: vector table plus reset sequences.
// Stall counter expectations follow FETCH_STALL_CNT_EN.
module tb_pipe_fetch_ctrl;

    typedef struct {
        logic        ack;
        logic [31:0] rd;
        logic        w;
        logic [1:0]  ps;
        logic [31:0] b;
        logic [31:0] j;
        logic [31:0] r;
        logic        req;
        logic [31:0] addr;
        logic        fv;
        logic [31:0] inst;
        logic [31:0] pc4;
        logic [31:0] stall;
    } vec_t;

    logic        clock;
    logic        resetn;
    logic [1:0]  pcsource;
    logic [31:0] bpc, jpc, rpc;
    logic        wpcir;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] pc;
    logic        f_valid;
    logic [31:0] f_inst;
    logic [31:0] f_pc4;
    logic [31:0] stall_cnt;

    int passed = 0;
    int total  = 0;
    int row    = 0;

    vec_t tbl[$];
    vec_t post[$];
    vec_t sb[$];

    pipe_fetch_ctrl dut (
        .clock      (clock),
        .resetn     (resetn),
        .pcsource   (pcsource),
        .bpc        (bpc),
        .jpc        (jpc),
        .rpc        (rpc),
        .wpcir      (wpcir),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .pc         (pc),
        .f_valid    (f_valid),
        .f_inst     (f_inst),
        .f_pc4      (f_pc4),
        .stall_cnt  (stall_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic vec_t mk(
        logic [31:0] ack, logic [31:0] rd, logic [31:0] w,
        logic [31:0] ps, logic [31:0] b, logic [31:0] j,
        logic [31:0] r, logic [31:0] req, logic [31:0] addr,
        logic [31:0] fv, logic [31:0] inst, logic [31:0] pc4,
        logic [31:0] stall);
        vec_t v;
        v.ack  = ack[0];
        v.rd   = rd;
        v.w    = w[0];
        v.ps   = ps[1:0];
        v.b    = b;
        v.j    = j;
        v.r    = r;
        v.req  = req[0];
        v.addr = addr;
        v.fv   = fv[0];
        v.inst = inst;
        v.pc4  = pc4;
`ifdef FETCH_STALL_CNT_EN
        v.stall = stall;
`else
        v.stall = 32'd0 & stall;
`endif
        return v;
    endfunction

    task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got === exp) begin
            passed++;
        end else begin
            $display("FAIL %s row%0d: got %h want %h", nm, row, got, exp);
        end
    endtask

    task automatic apply(vec_t v);
        vec_t e;
        @(negedge clock);
        imem_ack   = v.ack;
        imem_rdata = v.rd;
        wpcir      = v.w;
        pcsource   = v.ps;
        bpc        = v.b;
        jpc        = v.j;
        rpc        = v.r;
        sb.push_back(v);
        #2;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk("imem_req", {31'd0, imem_req}, {31'd0, e.req});
            chk("imem_addr", imem_addr, e.addr);
            chk("pc", pc, e.addr);
            chk("f_valid", {31'd0, f_valid}, {31'd0, e.fv});
            chk("stall_cnt", stall_cnt, e.stall);
            if (e.fv) begin
                chk("f_inst", f_inst, e.inst);
                chk("f_pc4", f_pc4, e.pc4);
            end
        end
        row++;
    endtask

    task automatic chk_reset(string tag);
        chk({tag, "_req"}, {31'd0, imem_req}, 32'd0);
        chk({tag, "_addr"}, imem_addr, 32'd0);
        chk({tag, "_pc"}, pc, 32'd0);
        chk({tag, "_fvalid"}, {31'd0, f_valid}, 32'd0);
        chk({tag, "_stall"}, stall_cnt, 32'd0);
    endtask

    initial begin
        resetn     = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = 32'h0;
        wpcir      = 1'b1;
        pcsource   = 2'b00;
        bpc        = 32'h0;
        jpc        = 32'h0;
        rpc        = 32'h0;

        tbl.push_back(mk(1, 'h11, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 'hA0, 1, 0, 0, 0, 0, 1, 0, 1, 'hA0, 4, 0));
        tbl.push_back(mk(1, 'hA4, 1, 0, 0, 0, 0, 1, 4, 1, 'hA4, 8, 0));
        tbl.push_back(mk(1, 'hA8, 1, 0, 0, 0, 0, 1, 8, 1, 'hA8, 'hC, 0));
        tbl.push_back(mk(1, 'hAC, 1, 0, 0, 0, 0, 1, 'hC, 1, 'hAC, 'h10, 0));
        tbl.push_back(mk(1, 'hB0, 1, 1, 'h100, 0, 0, 1, 'h10, 1, 'hB0, 'h14, 0));
        tbl.push_back(mk(1, 'hB1, 1, 0, 0, 0, 0, 1, 'h100, 1, 'hB1, 'h104, 0));
        tbl.push_back(mk(1, 'hB2, 1, 3, 0, 0, 'h20, 1, 'h104, 1, 'hB2, 'h108, 0));
        tbl.push_back(mk(0, 'hDEAD, 1, 2, 0, 'h400, 0, 1, 'h20, 0, 0, 0, 0));
        tbl.push_back(mk(0, 'hDEAD, 1, 0, 0, 0, 0, 1, 'h20, 0, 0, 0, 1));
        tbl.push_back(mk(0, 'hDEAD, 1, 1, 'h800, 0, 0, 1, 'h20, 0, 0, 0, 2));
        tbl.push_back(mk(1, 'hC20, 1, 0, 0, 0, 0, 1, 'h20, 1, 'hC20, 'h24, 3));
        tbl.push_back(mk(1, 'hC40, 1, 0, 0, 0, 0, 1, 'h400, 1, 'hC40, 'h404, 3));
        tbl.push_back(mk(1, 'hBEEF, 0, 1, 'h900, 0, 0, 1, 'h404, 1, 'hBEEF, 'h408, 3));
        tbl.push_back(mk(1, 'h1234, 0, 2, 0, 'h999, 0, 0, 'h404, 1, 'hBEEF, 'h408, 3));
        tbl.push_back(mk(0, 'h1234, 1, 0, 0, 0, 0, 0, 'h404, 1, 'hBEEF, 'h408, 3));
        tbl.push_back(mk(1, 'hC48, 1, 0, 0, 0, 0, 1, 'h408, 1, 'hC48, 'h40C, 3));
        tbl.push_back(mk(1, 'hC1, 0, 0, 0, 0, 0, 1, 'h40C, 1, 'hC1, 'h410, 3));
        tbl.push_back(mk(0, 0, 1, 3, 0, 0, 'hFFFFFFFC, 0, 'h40C, 1, 'hC1, 'h410, 3));
        tbl.push_back(mk(1, 'hF1, 1, 0, 0, 0, 0, 1, 'hFFFFFFFC, 1, 'hF1, 0, 3));
        for (int i = 0; i < 5; i++) begin
            tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 3 + i));
        end
        tbl.push_back(mk(1, 'hF2, 1, 0, 0, 0, 0, 1, 0, 1, 'hF2, 4, 8));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1, 4, 0, 0, 0, 8));
        tbl.push_back(mk(0, 0, 1, 1, 'h700, 0, 0, 1, 4, 0, 0, 0, 9));

        post.push_back(mk(1, 'h55, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        post.push_back(mk(1, 'hE0, 1, 0, 0, 0, 0, 1, 0, 1, 'hE0, 4, 0));
        for (int i = 0; i < 5; i++) begin
            post.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1, 4, 0, 0, 0, i));
        end
        post.push_back(mk(1, 'hE4, 1, 0, 0, 0, 0, 1, 4, 1, 'hE4, 8, 5));

        repeat (2) @(negedge clock);
        #2;
        chk_reset("por");
        @(posedge clock);
        #1 resetn = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i]);
        end

        @(posedge clock);
        #3 resetn = 1'b0;
        #1;
        chk_reset("async");
        @(posedge clock);
        #1;
        chk_reset("held");
        resetn = 1'b1;

        for (int i = 0; i < post.size(); i++) begin
            apply(post[i]);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
